// File: rtl/egk_pkg.sv
// Shared types for the Exp-Golomb bit packer: FSM state and codeword bundle.
package egk_pkg;
  localparam int EGK_MAX_BITS = 16;

  typedef enum logic [1:0] {RUN, DRAIN, PAD, DONE} pack_state_t;

  typedef struct packed {
    logic [EGK_MAX_BITS-1:0] code;
    logic [7:0]              len;
  } codeword_t;
endpackage

// File: rtl/egk_bit_merge.sv
// Combinational buffer update: optional word shift-out, then OR a right-aligned
// codeword into the left-aligned buffer directly below the (post-shift) fill point.
module egk_bit_merge
  import egk_pkg::*;
#(
  parameter int MAX_BITS = EGK_MAX_BITS,
  parameter int OUT_W    = 8,
  parameter int BUF_W    = MAX_BITS + OUT_W,
  parameter int FW       = $clog2(BUF_W)
) (
  input  logic [BUF_W-1:0]    i_buf,
  input  logic [FW-1:0]       i_fill,
  input  logic                i_shift,
  input  logic                i_acc,
  input  logic [MAX_BITS-1:0] i_code,
  input  logic [7:0]          i_len,
  output logic [BUF_W-1:0]    o_buf,
  output logic [FW-1:0]       o_fill
);
  logic [BUF_W-1:0] w_base;
  logic [BUF_W-1:0] w_code;
  logic [FW-1:0]    w_bfill;
  logic [7:0]       w_sh;

  always_comb begin
    w_base  = i_shift ? (i_buf << OUT_W) : i_buf;
    w_bfill = i_shift ? (i_fill - FW'(OUT_W)) : i_fill;
    // Strip any stray bits above code_len so they cannot corrupt earlier bits.
    w_code  = BUF_W'(i_code) & ((BUF_W'(1) << i_len) - BUF_W'(1));
    w_sh    = 8'(BUF_W) - 8'(w_bfill) - i_len;
    o_buf   = i_acc ? (w_base | (w_code << w_sh)) : w_base;
    o_fill  = i_acc ? (w_bfill + FW'(i_len)) : w_bfill;
  end
endmodule

// File: rtl/egk_bit_packer.sv
// Packs variable-length codewords MSB-first into OUT_W-bit words; flush drains the
// buffer, pads the last partial word and pulses flush_done.
module egk_bit_packer
  import egk_pkg::*;
#(
  parameter int   MAX_BITS = EGK_MAX_BITS,
  parameter int   OUT_W    = 8,
  parameter logic PAD_BIT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [MAX_BITS-1:0] code,
  input  logic [7:0]          code_len,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_word,
  output logic [3:0]          out_nbits,
  output logic                out_last,
  output logic                flush_done,
  output logic                len_err,
  output logic [31:0]         total_bits
);
  localparam int BUF_W = MAX_BITS + OUT_W;
  localparam int FW    = $clog2(BUF_W);

  pack_state_t      r_state;
  logic [BUF_W-1:0] r_buf;
  logic [FW-1:0]    r_fill;
  logic             r_live;
  logic             r_len_err;
  logic [31:0]      r_total;

  logic [7:0]       w_len;
  logic             w_acc;
  logic             w_fire;
  logic [BUF_W-1:0] w_buf_n;
  logic [FW-1:0]    w_fill_n;
  logic [OUT_W-1:0] w_top;
  logic [OUT_W-1:0] w_padmask;

  always_comb begin
    w_len     = (code_len > 8'(MAX_BITS)) ? 8'(MAX_BITS) : code_len;
    // r_live keeps in_ready low through reset and releases it one edge later.
    in_ready  = r_live && (r_state == RUN) && (r_fill < FW'(OUT_W));
    w_acc     = in_valid && in_ready;
    out_valid = (((r_state == RUN) || (r_state == DRAIN)) && (r_fill >= FW'(OUT_W)))
                || (r_state == PAD);
    w_fire    = out_valid && out_ready;
    w_top     = r_buf[BUF_W-1 -: OUT_W];
    w_padmask = {OUT_W{1'b1}} >> r_fill;
    out_word  = ((r_state == PAD) && PAD_BIT) ? (w_top | w_padmask) : w_top;
    out_nbits = (r_state == PAD) ? 4'(r_fill) : 4'(OUT_W);
    out_last  = (r_state == PAD) || ((r_state == DRAIN) && (r_fill == FW'(OUT_W)));
  end

  assign flush_done = (r_state == DONE);
  assign len_err    = r_len_err;
  assign total_bits = r_total;

  egk_bit_merge #(
    .MAX_BITS(MAX_BITS), .OUT_W(OUT_W), .BUF_W(BUF_W), .FW(FW)
  ) u_merge (
    .i_buf  (r_buf),
    .i_fill (r_fill),
    .i_shift(w_fire && (r_state != PAD)),
    .i_acc  (w_acc),
    .i_code (code),
    .i_len  (w_len),
    .o_buf  (w_buf_n),
    .o_fill (w_fill_n)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_buf     <= '0;
      r_fill    <= '0;
      r_live    <= 1'b0;
      r_len_err <= 1'b0;
      r_total   <= '0;
    end else begin
      r_live <= 1'b1;
      r_buf  <= w_buf_n;
      r_fill <= w_fill_n;
      if (w_acc) r_total <= r_total + 32'(w_len);
      if (w_acc && (code_len > 8'(MAX_BITS))) r_len_err <= 1'b1;
      case (r_state)
        RUN:   if (flush) r_state <= DRAIN;
        DRAIN: if (r_fill < FW'(OUT_W)) r_state <= (r_fill == '0) ? DONE : PAD;
        PAD: if (w_fire) begin
          r_buf   <= '0;
          r_fill  <= '0;
          r_state <= DONE;
        end
        DONE:    r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_egk_bit_packer.sv
// Bench for egk_bit_packer: bit-queue reference model checked every cycle, plus
// directed literal cases and a randomized phase.
module tb_egk_bit_packer;
  import egk_pkg::*;

  localparam int MB = 16;
  localparam int OW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [MB-1:0] code = '0;
  logic [7:0]    code_len = '0;
  logic          in_ready, out_valid, out_last, flush_done, len_err;
  logic [OW-1:0] out_word;
  logic [3:0]    out_nbits;
  logic [31:0]   total_bits;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  egk_bit_packer #(.MAX_BITS(MB), .OUT_W(OW), .PAD_BIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code(code), .code_len(code_len), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_nbits(out_nbits),
    .out_last(out_last), .flush_done(flush_done), .len_err(len_err),
    .total_bits(total_bits)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending bits as a queue, phase 0=run 1=drain 2=pad 3=done.
  bit          mq[$];
  int          mph = 0;
  bit          mlive = 1'b0;
  bit          merr = 1'b0;
  logic [31:0] mtot = '0;

  function automatic bit m_rdy();
    return mlive && (mph == 0) && (mq.size() < OW);
  endfunction

  function automatic bit m_oval();
    return (((mph == 0) || (mph == 1)) && (mq.size() >= OW)) || (mph == 2);
  endfunction

  function automatic logic [OW-1:0] m_word();
    logic [OW-1:0] w;
    for (int i = 0; i < OW; i++) w[OW-1-i] = (i < mq.size()) ? mq[i] : 1'b0;
    return w;
  endfunction

  always @(posedge clk) begin : model
    bit fo, ac;
    int n, nph, ln;
    if (!rst_n) begin
      mq.delete();
      mph = 0; mlive = 1'b0; merr = 1'b0; mtot = '0;
    end else begin
      fo  = m_oval() && out_ready;
      ac  = in_valid && m_rdy();
      nph = mph;
      case (mph)
        0: if (flush) nph = 1;
        1: if (mq.size() < OW) nph = (mq.size() == 0) ? 3 : 2;
        2: if (fo) nph = 3;
        default: nph = 0;
      endcase
      if (fo) begin
        n = (mph == 2) ? mq.size() : OW;
        repeat (n) void'(mq.pop_front());
      end
      if (ac) begin
        ln = (code_len > MB) ? MB : int'(code_len);
        for (int i = ln - 1; i >= 0; i--) mq.push_back(code[i]);
        mtot += 32'(ln);
        if (code_len > MB) merr = 1'b1;
      end
      mph   = nph;
      mlive = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_in_ready", 32'(in_ready), 32'(m_rdy()));
      chk("m_out_valid", 32'(out_valid), 32'(m_oval()));
      chk("m_flush_done", 32'(flush_done), 32'(mph == 3));
      chk("m_len_err", 32'(len_err), 32'(merr));
      chk("m_total_bits", total_bits, mtot);
      if (m_oval()) begin
        chk("m_out_word", 32'(out_word), 32'(m_word()));
        chk("m_out_nbits", 32'(out_nbits), (mph == 2) ? 32'(mq.size()) : 32'(OW));
        chk("m_out_last", 32'(out_last), 32'((mph == 2) || ((mph == 1) && (mq.size() == OW))));
      end
    end
  end

  initial begin
    codeword_t cw;
    int r;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_total", total_bits, 0);
    chk("rst_len_err", 32'(len_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 1);

    // 101 + 11001 -> 0xB9, then a 5-cycle stall
    in_valid = 1'b1; code = 16'h5; code_len = 8'd3; out_ready = 1'b0;
    @(negedge clk);
    code = 16'h19; code_len = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b9_word", 32'(out_word), 32'h B9);
    chk("b9_nbits", 32'(out_nbits), 8);
    chk("b9_last", 32'(out_last), 0);
    chk("b9_valid", 32'(out_valid), 1);
    repeat (5) begin
      @(negedge clk);
      chk("stall_word", 32'(out_word), 32'hB9);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("b9_drained", 32'(out_valid), 0);
    chk("b9_total", total_bits, 8);

    // 16 ones -> two 0xFF words
    in_valid = 1'b1; code = 16'hFFFF; code_len = 8'd16;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ff1_word", 32'(out_word), 32'hFF);
    chk("ff1_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("ff2_word", 32'(out_word), 32'hFF);
    chk("ff2_valid", 32'(out_valid), 1);
    chk("ff2_ready", 32'(in_ready), 0);
    @(negedge clk);
    chk("ff_empty_valid", 32'(out_valid), 0);
    chk("ff_empty_ready", 32'(in_ready), 1);

    // 110 with flush in the same cycle -> padded 0xC0
    in_valid = 1'b1; code = 16'h6; code_len = 8'd3; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    chk("drain_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("pad_word", 32'(out_word), 32'hC0);
    chk("pad_nbits", 32'(out_nbits), 3);
    chk("pad_last", 32'(out_last), 1);
    chk("pad_valid", 32'(out_valid), 1);
    @(negedge clk);
    chk("pad_done", 32'(flush_done), 1);
    chk("pad_done_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("pad_done_once", 32'(flush_done), 0);
    chk("pad_run_ready", 32'(in_ready), 1);

    // over-long code_len clamps to 16 bits
    in_valid = 1'b1; code = 16'hFFFF; code_len = 8'd20;
    @(negedge clk);
    in_valid = 1'b0;
    chk("clamp_err", 32'(len_err), 1);
    chk("clamp_total", total_bits, 43);
    repeat (2) @(negedge clk);
    chk("clamp_drained", 32'(in_ready), 1);
    in_valid = 1'b1; code = 16'hABCD; code_len = 8'd0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("zero_total", total_bits, 43);
    chk("zero_valid", 32'(out_valid), 0);
    chk("zero_err_sticky", 32'(len_err), 1);

    // flush with nothing pending
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("eflush_early", 32'(flush_done), 0);
    @(negedge clk);
    chk("eflush_done", 32'(flush_done), 1);
    chk("eflush_valid", 32'(out_valid), 0);
    @(negedge clk);

    // reset while a 5-bit padded word is pending
    in_valid = 1'b1; code = 16'h1F; code_len = 8'd5; flush = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("pad5_valid", 32'(out_valid), 1);
    chk("pad5_nbits", 32'(out_nbits), 5);
    chk("pad5_word", 32'(out_word), 32'hF8);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstpad_valid", 32'(out_valid), 0);
    chk("rstpad_ready", 32'(in_ready), 0);
    chk("rstpad_total", total_bits, 0);
    chk("rstpad_err", 32'(len_err), 0);
    chk("rstpad_done", 32'(flush_done), 0);
    rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("rstpad_ready1", 32'(in_ready), 1);
    chk("rstpad_nowrd", 32'(out_valid), 0);

    // randomized phase, checked by the model
    for (int c = 0; c < 4000; c++) begin
      r = int'($urandom_range(0, 99));
      cw.code = 16'($urandom);
      cw.len  = (r < 3) ? 8'($urandom_range(17, 255)) : 8'($urandom_range(0, 16));
      rst_n     = ($urandom_range(0, 499) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      code      = cw.code;
      code_len  = cw.len;
      flush     = ($urandom_range(0, 29) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_valid = 1'b0; flush = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
